fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble instruction inserted into decode.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port StallF, input, 1: hazard unit freezes the fetch PC.
REQ-006 SHALL have port StallD, input, 1: hazard unit freezes the F/D register.
REQ-007 SHALL have port FlushD, input, 1: hazard unit replaces the F/D contents with a bubble.
REQ-008 SHALL have port PCSrcE, input, 1: taken branch or jump resolved in execute.
REQ-009 SHALL have port PCTargetE, input, 32: redirect address from execute.
REQ-010 SHALL have port imem_req, output, 1: read request, accepted in the cycle it is high.
REQ-011 SHALL have port imem_addr, output, 32: word address of the request, equal to PCF.
REQ-012 SHALL have port imem_valid, input, 1: response strobe, at least 1 cycle after the request.
REQ-013 SHALL have port imem_rdata, input, 32: instruction word, valid with imem_valid.
REQ-014 SHALL have outputs InstrD (32), PCD (32) and inc_PCD (32): F/D register contents driven to decode.
REQ-015 SHALL have port ValidD, output, 1: InstrD holds a real instruction (0 = bubble).

Function
REQ-016 SHALL hold PCF, a 32-bit register; the low 2 bits of every loaded value are forced to 0.
REQ-017 SHALL implement the FSM states IDLE, WAIT, HOLD and DROP, with at most one memory request outstanding.
REQ-018 In IDLE, with StallF=0 and PCSrcE=0, SHALL assert imem_req with imem_addr=PCF and move to WAIT; imem_req SHALL be 0 in every other state.
REQ-019 IDLE with PCSrcE=1: PCF<=PCTargetE, no request issued, stay in IDLE. IDLE with StallF=1: no request issued.
REQ-020 WAIT + imem_valid + PCSrcE=0 + StallD=0:
- deliver to F/D: InstrD=imem_rdata, PCD=PCF, inc_PCD=PCF+4, ValidD=1;
- PCF<=PCF+4; next state IDLE.
REQ-021 WAIT + imem_valid + PCSrcE=0 + StallD=1: capture imem_rdata in a 32-bit holding buffer; next state HOLD; PCF unchanged.
REQ-022 WAIT + imem_valid + PCSrcE=1: discard the response; PCF<=PCTargetE; next state IDLE.
REQ-023 WAIT + no imem_valid + PCSrcE=1: PCF<=PCTargetE; next state DROP.
REQ-024 DROP: the next imem_valid SHALL be discarded and the state moves to IDLE; a further PCSrcE in DROP SHALL only update PCF.
REQ-025 HOLD + PCSrcE=1: discard the buffer; PCF<=PCTargetE; next state IDLE.
REQ-026 HOLD + StallD=0: deliver the buffer as in REQ-020; PCF<=PCF+4; next state IDLE.
REQ-027 F/D register priority, highest first:
- rst;
- FlushD=1: load InstrD=NOP_INSTR, ValidD=0, PCD and inc_PCD unchanged;
- StallD=1: hold all F/D values;
- delivery: load as in REQ-020;
- otherwise: load a bubble (NOP_INSTR, ValidD=0).
REQ-028 FlushD and a delivery in the same cycle: the flush wins, and the delivered instruction is lost only if PCSrcE=1. With PCSrcE=0 the FSM treats the cycle as stalled and the instruction goes to HOLD.
REQ-029 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-030 Throughput SHALL be one instruction per 2 cycles with 1-cycle memory latency; the latency from request to ValidD is latency+1 cycles.

Reset
REQ-031 While rst=1 at a clock edge:
- PCF<=RESET_PC; state<=IDLE;
- InstrD=NOP_INSTR, PCD=0, inc_PCD=0, ValidD=0; holding buffer cleared;
- imem_req=0 during the reset cycle.
REQ-032 Reset asserted in WAIT SHALL go to DROP instead of IDLE, so that a response still in flight is discarded; PCF<=RESET_PC.

Verification
REQ-033 Reset, then 1-cycle memory returning 32'h00500093 at address 0 -> imem_addr=0; InstrD=32'h00500093, PCD=0, inc_PCD=4, ValidD=1; next imem_addr=4.
REQ-034 StallD=1 for 3 cycles while a response arrives -> F/D held; delivered unchanged once StallD=0; no duplicate or lost instruction.
REQ-035 PCSrcE=1 with PCTargetE=32'h0000_0100 while in WAIT, response 2 cycles later -> response discarded; next request imem_addr=32'h100; ValidD stays 0 meanwhile.
REQ-036 FlushD=1 together with PCSrcE=1 at delivery -> InstrD=32'h00000013, ValidD=0; next fetch at the target.
REQ-037 PCF=32'hFFFF_FFFC delivered -> inc_PCD=0, next imem_addr=0.
REQ-038 rst pulsed while a response is outstanding -> late response ignored; first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and the memory.
// One request may be outstanding; the response strobe arrives at least one cycle later.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Pipelined instruction fetch: PC register, single-outstanding memory request FSM,
// and the F/D pipeline register with stall, flush and bubble insertion.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          inc_PCD,
  output logic                 ValidD
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pcf_reg, pcf_next;
  logic [31:0] hold_reg, hold_next;
  logic [31:0] instr_reg, pcd_reg, inc_pcd_reg;
  logic        valid_reg;
  logic        req_next;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic        fd_blocked;

  assign pc_plus4       = pcf_reg + 32'd4;
  assign target_aligned = PCTargetE & 32'hFFFF_FFFC;
  // A flush without redirect must not lose the word: treat it like a stall and park it.
  assign fd_blocked     = StallD | FlushD;

  always_comb begin
    state_next    = state_reg;
    pcf_next      = pcf_reg;
    hold_next     = hold_reg;
    req_next      = 1'b0;
    deliver       = 1'b0;
    deliver_instr = imem.imem_rdata;
    case (state_reg)
      IDLE: begin
        if (PCSrcE) begin
          pcf_next = target_aligned;
        end else if (!StallF) begin
          req_next   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (PCSrcE) begin
          pcf_next   = target_aligned;
          state_next = imem.imem_valid ? IDLE : DROP;
        end else if (imem.imem_valid) begin
          if (fd_blocked) begin
            hold_next  = imem.imem_rdata;
            state_next = HOLD;
          end else begin
            deliver    = 1'b1;
            pcf_next   = pc_plus4;
            state_next = IDLE;
          end
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcf_next   = target_aligned;
          hold_next  = '0;
          state_next = IDLE;
        end else if (!fd_blocked) begin
          deliver       = 1'b1;
          deliver_instr = hold_reg;
          pcf_next      = pc_plus4;
          state_next    = IDLE;
        end
      end
      DROP: begin
        if (PCSrcE) begin
          pcf_next = target_aligned;
        end
        if (imem.imem_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem.imem_req  = req_next & ~rst;
  assign imem.imem_addr = pcf_reg;

  // Reset during WAIT still has a response in flight, so it must be swallowed in DROP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= (state_reg == WAIT) ? DROP : IDLE;
      pcf_reg   <= RESET_PC & 32'hFFFF_FFFC;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pcf_reg   <= pcf_next;
      hold_reg  <= hold_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg   <= NOP_INSTR;
      pcd_reg     <= '0;
      inc_pcd_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (FlushD) begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (StallD) begin
      instr_reg <= instr_reg;
      valid_reg <= valid_reg;
    end else if (deliver) begin
      instr_reg   <= deliver_instr;
      pcd_reg     <= pcf_reg;
      inc_pcd_reg <= pc_plus4;
      valid_reg   <= 1'b1;
    end else begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end
  end

  assign InstrD  = instr_reg;
  assign PCD     = pcd_reg;
  assign inc_PCD = inc_pcd_reg;
  assign ValidD  = valid_reg;

endmodule
